// File: rtl/freq_meter.sv
// -----------------------------------------------------------------------------
// freq_meter
// Counts rising edges of a slow asynchronous signal over a fixed gate window
// timed from the 50 MHz system clock. It reports the count of each completed
// window together with a one-cycle valid strobe.
//
// Parameters
//   GATE_CYCLES  gate window length in clk_50mHz cycles (>= 2)
//   CNT_W        width of the edge counter and of freq
//   SYNC_STAGES  flip-flop stages in the sig_in synchronizer (>= 2)
//
// Ports
//   clk_50mHz   in   1      system clock
//   rst         in   1      synchronous reset, active-high
//   en          in   1      high = run back-to-back gate windows
//   sig_in      in   1      asynchronous signal under measurement
//   freq        out  CNT_W  rising-edge count of the last completed window
//   freq_valid  out  1      one-cycle pulse when freq is updated
//   overflow    out  1      last completed window saturated the edge counter
//   busy        out  1      high while a gate window is in progress
// -----------------------------------------------------------------------------
module freq_meter #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int CNT_W       = 26,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_50mHz,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic             overflow,
    output logic             busy
);

    localparam int                GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic {
        IDLE,
        GATE
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_out;
    logic                   edge_d;
    logic                   rise;

    logic [GATE_W-1:0] gate_cnt, gate_cnt_next;
    logic [CNT_W-1:0]  edge_cnt, edge_cnt_next;
    logic [CNT_W-1:0]  edge_inc;
    logic [CNT_W-1:0]  freq_next;
    logic              ovf, ovf_next;
    logic              overflow_next;
    logic              freq_valid_next;
    logic              at_max;
    logic              last_cycle;

    // The synchronizer and edge detector run in every state, so a rise that
    // arrives while idle is already consumed before a window opens.
    always_ff @(posedge clk_50mHz) begin
        if (rst) begin
            sync_reg <= '0;
            edge_d   <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], sig_in};
            edge_d   <= sync_out;
        end
    end

    assign sync_out   = sync_reg[SYNC_STAGES-1];
    assign rise       = sync_out & ~edge_d;
    assign at_max     = (edge_cnt == CNT_MAX);
    assign last_cycle = (gate_cnt == GATE_LAST);

    // Saturating edge count including the current cycle's rise.
    assign edge_inc   = (rise && !at_max) ? edge_cnt + CNT_W'(1) : edge_cnt;

    // Next-state and output decode. On the last gate cycle the result is
    // published and the counters restart at once, so consecutive windows
    // abut with no dead cycle. An abort leaves the published result alone.
    always_comb begin
        state_next      = state;
        gate_cnt_next   = gate_cnt;
        edge_cnt_next   = edge_cnt;
        ovf_next        = ovf;
        freq_next       = freq;
        overflow_next   = overflow;
        freq_valid_next = 1'b0;
        busy            = 1'b0;

        case (state)
            IDLE: begin
                if (en) begin
                    state_next    = GATE;
                    gate_cnt_next = '0;
                    edge_cnt_next = '0;
                    ovf_next      = 1'b0;
                end
            end
            GATE: begin
                busy = 1'b1;
                if (!en) begin
                    state_next = IDLE;
                end else if (last_cycle) begin
                    freq_next       = edge_inc;
                    overflow_next   = ovf | (rise & at_max);
                    freq_valid_next = 1'b1;
                    gate_cnt_next   = '0;
                    edge_cnt_next   = '0;
                    ovf_next        = 1'b0;
                end else begin
                    gate_cnt_next = gate_cnt + GATE_W'(1);
                    edge_cnt_next = edge_inc;
                    ovf_next      = ovf | (rise & at_max);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and result registers; reset overrides en.
    always_ff @(posedge clk_50mHz) begin
        if (rst) begin
            state      <= IDLE;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            ovf        <= 1'b0;
            freq       <= '0;
            overflow   <= 1'b0;
            freq_valid <= 1'b0;
        end else begin
            state      <= state_next;
            gate_cnt   <= gate_cnt_next;
            edge_cnt   <= edge_cnt_next;
            ovf        <= ovf_next;
            freq       <= freq_next;
            overflow   <= overflow_next;
            freq_valid <= freq_valid_next;
        end
    end

endmodule
